d_cache: RTL
============

D_CACHE -- requirements
Module: d_cache

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port proc_read, input, 1 bit: processor load request.
REQ-004 SHALL have port proc_write, input, 1 bit: processor store request.
REQ-005 SHALL have port proc_addr, input, 30 bits: word address; tag=[29:5], index=[4:2], offset=[1:0].
REQ-006 SHALL have port proc_wdata, input, 32 bits: store data.
REQ-007 SHALL have port proc_rdata, output, 32 bits: load data, valid when proc_stall=0.
REQ-008 SHALL have port proc_stall, output, 1 bit: processor must hold request and freeze PC while high.
REQ-009 SHALL have port mem_read, output, 1 bit: block fetch request to memory.
REQ-010 SHALL have port mem_write, output, 1 bit: block writeback request to memory.
REQ-011 SHALL have port mem_addr, output, 28 bits: block address {tag,index}.
REQ-012 SHALL have port mem_wdata, output, 128 bits: writeback block, word0 in [31:0].
REQ-013 SHALL have port mem_rdata, input, 128 bits: fetched block, valid when mem_ready=1.
REQ-014 SHALL have port mem_ready, input, 1 bit: single-cycle completion pulse from memory.

Function
REQ-015 SHALL be direct-mapped, 8 lines x 4 words, write-back, write-allocate; each line holds valid, dirty, 25-bit tag.
REQ-016 SHALL use states COMPARE, WRITEBACK, ALLOCATE.
REQ-017 Hit SHALL mean line valid and stored tag equals proc_addr[29:5].
REQ-018 In COMPARE with request and hit: proc_stall=0 combinationally in the same cycle; proc_rdata = selected word; a write updates the word and sets dirty at the clock edge.
REQ-019 In COMPARE with no request: proc_stall=0, proc_rdata=0, no state change.
REQ-020 In COMPARE with request and miss: proc_stall=1; next state WRITEBACK if line valid and dirty, else ALLOCATE.
REQ-021 In WRITEBACK: mem_write=1, mem_addr={old tag,index}, mem_wdata=line data; all held stable until mem_ready; on mem_ready go to ALLOCATE.
REQ-022 In ALLOCATE: mem_read=1, mem_addr=proc_addr[29:2]; on mem_ready load mem_rdata, set valid=1, dirty=0, tag=proc_addr[29:5], and go to COMPARE.
REQ-023 The first COMPARE cycle after ALLOCATE SHALL hit, giving miss latency 2 + memory wait cycles for a clean line.
REQ-024 mem_read and mem_write SHALL never be high together; both SHALL be 0 in COMPARE.
REQ-025 proc_read and proc_write both high SHALL be treated as a write.
REQ-026 mem_ready asserted in COMPARE SHALL be ignored.

Reset
REQ-027 On rst=1 at a clock edge: all valid and dirty bits clear, state is COMPARE, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-028 Reset during WRITEBACK or ALLOCATE SHALL abort the transaction and discard any pending block, with memory requests low from the next cycle.
REQ-029 Tag and data arrays need not be reset.

Configuration
REQ-030 With macro D_CACHE_STATS_EN defined, the block SHALL add outputs hit_cnt[15:0] and miss_cnt[15:0], both reset to 0 and saturating at 16'hFFFF.
REQ-031 miss_cnt SHALL increment once per COMPARE-to-WRITEBACK/ALLOCATE transition.
REQ-032 hit_cnt SHALL increment on a completed request only if that request caused no miss.
REQ-033 Without D_CACHE_STATS_EN, these ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-034 Read miss, clean: after reset, read addr 30'h0000_0005 -> proc_stall=1, mem_read=1, mem_addr=28'h1; mem_ready with block {D,C,B,A} -> the next cycle has proc_stall=0, proc_rdata=B.
REQ-035 Write hit: after REQ-034, write 32'hDEADBEEF to addr 30'h6 -> no stall; a following read of 30'h6 returns 32'hDEADBEEF.
REQ-036 Dirty eviction: after REQ-035, read 30'h26 (same index 1, tag 1) -> mem_write=1, mem_addr=28'h1, mem_wdata[95:64]=32'hDEADBEEF; then mem_read=1, mem_addr=28'h9.
REQ-037 Stretched memory: hold mem_ready low 10 cycles in ALLOCATE -> mem_read and mem_addr stable, proc_stall=1 throughout.
REQ-038 Reset in ALLOCATE: assert rst for one cycle -> mem_read=0 next cycle; the same read misses again.
REQ-039 Stats (D_CACHE_STATS_EN): run REQ-034 to REQ-036 -> hit_cnt=2, miss_cnt=2.

Source files
------------

// File: rtl/d_cache.sv
// d_cache: direct-mapped, write-back, write-allocate data cache.
//   8 lines x 4 words of 32 bits. Each line has a valid bit, a dirty bit and a 25-bit tag.
//   The word address splits into tag=[29:5], index=[4:2] and offset=[1:0].
//   The controller has three states: COMPARE, WRITEBACK and ALLOCATE.
//
// Ports
//   clk, rst          : single clock; synchronous active-high reset
//   proc_read/write   : processor load / store request (both high counts as a store)
//   proc_addr[29:0]   : processor word address
//   proc_wdata[31:0]  : store data
//   proc_rdata[31:0]  : load data, valid while proc_stall=0
//   proc_stall        : processor must hold its request while this is high
//   mem_read/write    : block fetch / writeback request (registered)
//   mem_addr[27:0]    : block address {tag,index} (registered)
//   mem_wdata[127:0]  : writeback block, word0 in [31:0] (registered)
//   mem_rdata[127:0]  : fetched block, valid with mem_ready
//   mem_ready         : single-cycle completion pulse from memory
//
// Optional feature: define D_CACHE_STATS_EN to add the saturating outputs
// hit_cnt[15:0] and miss_cnt[15:0].
module d_cache (
    input  logic         clk,
    input  logic         rst,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
`ifdef D_CACHE_STATS_EN
    ,
    output logic [15:0]  hit_cnt,
    output logic [15:0]  miss_cnt
`endif
);

    typedef enum logic [1:0] {
        COMPARE   = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t         state_r;
    logic [7:0]     valid_r;
    logic [7:0]     dirty_r;
    logic [24:0]    tag_r  [0:7];
    logic [127:0]   data_r [0:7];

    logic [24:0]    tag_s;
    logic [2:0]     index_s;
    logic [1:0]     offset_s;
    logic [127:0]   line_data_s;
    logic           req_s;
    logic           hit_s;
    logic           write_hit_s;
    logic           fill_s;
    logic           miss_s;

    // Address decode, hit detection and the processor-side combinational response
    always_comb begin
        tag_s       = proc_addr[29:5];
        index_s     = proc_addr[4:2];
        offset_s    = proc_addr[1:0];
        line_data_s = data_r[index_s];
        req_s       = proc_read | proc_write;
        hit_s       = valid_r[index_s] && (tag_r[index_s] == tag_s);
        miss_s      = (state_r == COMPARE) && req_s && !hit_s;
        // A store wins over a load when both are requested.
        write_hit_s = (state_r == COMPARE) && proc_write && hit_s && !rst;
        // A fill arriving in the same cycle as reset is discarded.
        fill_s      = (state_r == ALLOCATE) && mem_ready && !rst;
        if (state_r == COMPARE) begin
            proc_stall = req_s && !hit_s;
            if (req_s && hit_s) begin
                proc_rdata = line_data_s[{offset_s, 5'b00000} +: 32];
            end else begin
                proc_rdata = 32'h0000_0000;
            end
        end else begin
            proc_stall = 1'b1;
            proc_rdata = 32'h0000_0000;
        end
    end

    // Tag and data arrays: block fill from memory or word merge on a store hit
    always_ff @(posedge clk) begin
        if (fill_s) begin
            data_r[index_s] <= mem_rdata;
            tag_r[index_s]  <= tag_s;
        end else if (write_hit_s) begin
            data_r[index_s][{offset_s, 5'b00000} +: 32] <= proc_wdata;
        end
    end

    // Controller FSM with registered memory-side outputs and line status bits
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= COMPARE;
            valid_r   <= 8'h00;
            dirty_r   <= 8'h00;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= 28'h000_0000;
            mem_wdata <= 128'h0;
        end else begin
            case (state_r)
                COMPARE: begin
                    if (req_s && hit_s) begin
                        if (proc_write) begin
                            dirty_r[index_s] <= 1'b1;
                        end
                    end else if (req_s) begin
                        // Miss: evict a dirty victim first, else fetch straight away.
                        if (valid_r[index_s] && dirty_r[index_s]) begin
                            state_r   <= WRITEBACK;
                            mem_write <= 1'b1;
                            mem_addr  <= {tag_r[index_s], index_s};
                            mem_wdata <= line_data_s;
                        end else begin
                            state_r   <= ALLOCATE;
                            mem_read  <= 1'b1;
                            mem_addr  <= proc_addr[29:2];
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ready) begin
                        state_r   <= ALLOCATE;
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                        mem_addr  <= proc_addr[29:2];
                        mem_wdata <= 128'h0;
                    end
                end
                ALLOCATE: begin
                    if (mem_ready) begin
                        state_r          <= COMPARE;
                        mem_read         <= 1'b0;
                        mem_addr         <= 28'h000_0000;
                        valid_r[index_s] <= 1'b1;
                        dirty_r[index_s] <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= COMPARE;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

`ifdef D_CACHE_STATS_EN
    // Remembers that the request now pending already missed, so its final hit is not counted
    logic missed_r;

    // Saturating hit / miss statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= 16'h0000;
            miss_cnt <= 16'h0000;
            missed_r <= 1'b0;
        end else begin
            if (miss_s) begin
                missed_r <= 1'b1;
                if (miss_cnt != 16'hFFFF) begin
                    miss_cnt <= miss_cnt + 16'h0001;
                end
            end else if ((state_r == COMPARE) && req_s && hit_s) begin
                missed_r <= 1'b0;
                if (!missed_r && (hit_cnt != 16'hFFFF)) begin
                    hit_cnt <= hit_cnt + 16'h0001;
                end
            end
        end
    end
`endif

endmodule
